neda_serial_dp: RTL and testbench
=================================

// Module: neda_serial_dp
// PURPOSE
//  Parametrised, sequential successor of the combinational NEDA dot-product unit.
//  Computes y = sum_{i=0..N_TAPS-1} A_i * x_i with bit-serial NEDA: one x bit-slice per cycle,
//  each slice selects and adds the stored coefficients, then shift-accumulates.
//  Sits between a sample source and a result consumer using valid/ready handshakes;
//  the coefficient vector is loadable at run time.
// PARAMETERS
//  N_TAPS  8   number of taps (coefficient/sample pairs)
//  X_W     8   sample width; also the number of RUN cycles per result
//  A_W     8   coefficient width
//  Y_W     24  result width; full precision requires Y_W >= X_W+A_W+clog2(N_TAPS), else LSBs kept
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous, active-low reset
//  coef_we    in   1             coefficient write strobe
//  coef_in    in   N_TAPS*A_W    coefficients; A_i = coef_in[i*A_W +: A_W]
//  in_valid   in   1             sample vector valid
//  in_ready   out  1             block can accept a sample vector
//  x_in       in   N_TAPS*X_W    samples; x_i = x_in[i*X_W +: X_W]
//  out_valid  out  1             y holds a finished result
//  out_ready  in   1             consumer accepts y
//  y          out  Y_W           dot-product result
//  busy       out  1             high in RUN or DONE
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, coefficient regs=0, x regs=0, acc=0, bit_cnt=0,
//    y=0, out_valid=0, in_ready=1, busy=0. Reset mid-RUN/DONE aborts and discards the job.
//  - FSM IDLE -> RUN -> DONE -> IDLE. in_ready=1 only in IDLE; busy = (state!=IDLE).
//  - Coefficient write: coef_we in IDLE latches coef_in at the edge; coef_we in RUN/DONE ignored.
//  - Accept: in_valid && in_ready at edge k latches x_in, clears acc, bit_cnt=0, goes RUN.
//    coef_we and accept in same edge: job uses the newly written coefficients (write-through).
//  - RUN: edges k+1..k+X_W process bit b=bit_cnt (LSB first):
//    slice_b = sum of A_i for all i with x_i[b]=1 (0 if none);
//    acc <= acc + (slice_b << b); bit_cnt increments; at b=X_W-1 state->DONE.
//  - Latency: out_valid visible after edge k+X_W (X_W cycles after acceptance); y=final acc.
//  - DONE: y and out_valid held stable until out_valid && out_ready; then IDLE, out_valid=0
//    at that edge; y keeps last value. No new acceptance in the handover cycle (in_ready low).
//  - Throughput: one result per X_W+2 cycles with out_ready tied high.
//  - Arithmetic (default): x and A unsigned; acc Y_W bits, wrap-around modulo 2^Y_W, no saturation.
//  - in_valid while not ready: ignored, source must hold; x_in changes outside accept have no effect.
// CONFIGURATION
//  NEDA_SIGNED_EN defined: x_i and A_i are two's complement; slice sums sign-extended to Y_W;
//    MSB slice (b=X_W-1) is subtracted: acc <= acc - (slice_b << b). y is two's complement.
//  NEDA_SIGNED_EN undefined: all operands unsigned, all slices added (default above).
// TESTING
//  1 A5=56,A6=198,A7=85, others 0; all x_i=49 -> y=16611 (0x0040E3), out_valid X_W=8 cycles after accept.
//  2 Same stimulus with NEDA_SIGNED_EN (A6=-58) -> y=4067 (0x000FE3).
//  3 All A_i=255, all x_i=255, unsigned -> y=520200 (0x07F008); all x_i=0 -> y=0.
//  4 Hold out_ready=0 for 5 cycles in DONE -> y/out_valid stable, in_ready=0; release -> IDLE next edge.
//  5 coef_we during RUN with new values -> ignored, result uses old coefficients; next job after
//    IDLE write uses new ones; coef_we+accept same edge -> new coefficients used.
//  6 Assert rst_n=0 at bit 3 of RUN -> outputs return to reset values immediately; coefficients=0;
//    following job with reloaded coefficients gives correct y.

Source files
------------

// File: rtl/neda_serial_dp.sv
// neda_serial_dp: bit-serial NEDA dot-product unit, y = sum_i A_i * x_i.
// One sample bit-slice is processed per cycle, LSB first. Each slice adds the
// coefficients whose sample bit is set, and the sum is shift-accumulated.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   coef_we, coef_in      coefficient load (accepted in IDLE only); A_i = coef_in[i*A_W +: A_W]
//   in_valid, in_ready    sample-vector handshake; x_i = x_in[i*X_W +: X_W]
//   x_in                  sample vector
//   out_valid, out_ready  result handshake; y is held while out_valid is high
//   y                     dot-product result (Y_W bits, wraps modulo 2^Y_W)
//   busy                  high in RUN or DONE
//
// Configuration macro: NEDA_SIGNED_EN selects two's-complement operands, where the
// MSB slice is subtracted. When undefined, all operands are unsigned.
module neda_serial_dp #(
  parameter int unsigned N_TAPS = 8,
  parameter int unsigned X_W    = 8,
  parameter int unsigned A_W    = 8,
  parameter int unsigned Y_W    = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  coef_we,
  input  logic [N_TAPS*A_W-1:0] coef_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_TAPS*X_W-1:0] x_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Y_W-1:0]        y,
  output logic                  busy
);

  localparam int unsigned CntW = (X_W > 1) ? $clog2(X_W) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [N_TAPS*A_W-1:0] coef_q, coef_d;
  logic [N_TAPS*X_W-1:0] x_q, x_d;
  logic [Y_W-1:0]        acc_q, acc_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;

  logic [Y_W-1:0] slice;
  logic [Y_W-1:0] slice_shifted;
  logic [Y_W-1:0] acc_next;
  logic           last_bit;

  // Sum of coefficients selected by the current sample bit-slice.
  always_comb begin
    logic [X_W-1:0] x_tap;
    logic [A_W-1:0] a_tap;
    slice = '0;
    for (int i = 0; i < int'(N_TAPS); i++) begin
      x_tap = x_q[i*X_W +: X_W];
      a_tap = coef_q[i*A_W +: A_W];
      if (x_tap[bit_cnt_q]) begin
`ifdef NEDA_SIGNED_EN
        slice = slice + Y_W'($signed(a_tap));
`else
        slice = slice + Y_W'(a_tap);
`endif
      end
    end
  end

  assign last_bit      = (bit_cnt_q == CntW'(X_W - 1));
  assign slice_shifted = slice << bit_cnt_q;

`ifdef NEDA_SIGNED_EN
  // The MSB of a two's-complement sample carries negative weight.
  assign acc_next = last_bit ? (acc_q - slice_shifted) : (acc_q + slice_shifted);
`else
  assign acc_next = acc_q + slice_shifted;
`endif

  always_comb begin
    state_d   = state_q;
    coef_d    = coef_q;
    x_d       = x_q;
    acc_d     = acc_q;
    y_d       = y_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      StIdle: begin
        // Write-through: a job accepted on the same edge sees the new coefficients.
        if (coef_we) coef_d = coef_in;
        if (in_valid) begin
          x_d       = x_in;
          acc_d     = '0;
          bit_cnt_d = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        acc_d     = acc_next;
        bit_cnt_d = bit_cnt_q + CntW'(1);
        if (last_bit) begin
          y_d     = acc_next;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      coef_q    <= '0;
      x_q       <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      coef_q    <= coef_d;
      x_q       <= x_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign y         = y_q;

endmodule

// File: tb/tb_neda_serial_dp.sv
// Self-checking bench for neda_serial_dp: directed jobs, expected results from a
// multiply-accumulate model pushed to a scoreboard at acceptance and popped at out_valid.
module tb_neda_serial_dp;

  localparam int unsigned N_TAPS = 8;
  localparam int unsigned X_W    = 8;
  localparam int unsigned A_W    = 8;
  localparam int unsigned Y_W    = 24;
  localparam int unsigned CW     = N_TAPS * A_W;
  localparam int unsigned XW     = N_TAPS * X_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          coef_we = 1'b0;
  logic [CW-1:0] coef_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] x_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [Y_W-1:0] y;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0]  coef_shadow = '0;
  logic [Y_W-1:0] sb[$];
  logic [Y_W-1:0] last_y;

  neda_serial_dp #(
    .N_TAPS(N_TAPS),
    .X_W   (X_W),
    .A_W   (A_W),
    .Y_W   (Y_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .coef_we  (coef_we),
    .coef_in  (coef_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [Y_W-1:0] model(input logic [CW-1:0] c, input logic [XW-1:0] xv);
    longint acc = 0;
    longint a, xi;
    logic [A_W-1:0] at;
    logic [X_W-1:0] xt;
    for (int i = 0; i < int'(N_TAPS); i++) begin
      at = c[i*A_W +: A_W];
      xt = xv[i*X_W +: X_W];
`ifdef NEDA_SIGNED_EN
      a  = $signed(at);
      xi = $signed(xt);
`else
      a  = longint'(at);
      xi = longint'(xt);
`endif
      acc += a * xi;
    end
    return acc[Y_W-1:0];
  endfunction

  function automatic logic [XW-1:0] all_x(input logic [X_W-1:0] v);
    logic [XW-1:0] r;
    for (int i = 0; i < int'(N_TAPS); i++) r[i*X_W +: X_W] = v;
    return r;
  endfunction

  function automatic logic [CW-1:0] all_a(input logic [A_W-1:0] v);
    logic [CW-1:0] r;
    for (int i = 0; i < int'(N_TAPS); i++) r[i*A_W +: A_W] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coef(input logic [CW-1:0] c);
    coef_we = 1'b1;
    coef_in = c;
    tick();
    coef_we = 1'b0;
    coef_in = CW'({$urandom(), $urandom()});
    coef_shadow = c;
  endtask

  // One job: accept, optional coefficient writes, wait for result, hold, release.
  task automatic run_job(input string tag, input logic [XW-1:0] xv, input int hold,
                         input logic wr_same, input logic [CW-1:0] new_coef,
                         input logic wr_run);
    int n;
    int cyc;
    logic [Y_W-1:0] exp;
    in_valid = 1'b1;
    x_in     = xv;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_accept_wait"}, 64'(n < 100), 64'd1);
    if (wr_same) begin
      coef_we = 1'b1;
      coef_in = new_coef;
      coef_shadow = new_coef;
    end
    sb.push_back(model(coef_shadow, xv));
    tick();
    coef_we  = 1'b0;
    in_valid = 1'b0;
    x_in     = XW'({$urandom(), $urandom()});
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      coef_we = wr_run && (cyc == 2);
      if (coef_we) coef_in = CW'({$urandom(), $urandom()});
      tick();
      cyc++;
    end
    coef_we = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'(X_W));
    exp = sb.pop_front();
    chk({tag, "_y"}, 64'(y), 64'(exp));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_y"}, 64'(y), 64'(exp));
      chk({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_release_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_release_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_release_y"}, 64'(y), 64'(exp));
    last_y = y;
  endtask

  logic [CW-1:0] c_tc1;
  logic [CW-1:0] c_alt;
  logic [CW-1:0] c_alt2;

  initial begin
    // Reset state
    #3;
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Sparse coefficients, uniform samples
    c_tc1 = '0;
    c_tc1[5*A_W +: A_W] = 8'd56;
    c_tc1[6*A_W +: A_W] = 8'd198;
    c_tc1[7*A_W +: A_W] = 8'd85;
    load_coef(c_tc1);
    run_job("tc1", all_x(8'd49), 0, 1'b0, '0, 1'b0);
`ifdef NEDA_SIGNED_EN
    chk("tc2_literal", 64'(last_y), 64'd4067);
`else
    chk("tc1_literal", 64'(last_y), 64'd16611);
`endif

    // Full-scale and all-zero samples
    load_coef(all_a(8'hFF));
    run_job("tc3_max", all_x(8'hFF), 0, 1'b0, '0, 1'b0);
`ifndef NEDA_SIGNED_EN
    chk("tc3_literal", 64'(last_y), 64'd520200);
`endif
    run_job("tc3_zero", all_x(8'h00), 0, 1'b0, '0, 1'b0);
    chk("tc3_zero_literal", 64'(last_y), 64'd0);

    // Back-pressure in DONE
    c_alt = CW'({$urandom(), $urandom()});
    load_coef(c_alt);
    run_job("tc4_hold", XW'({$urandom(), $urandom()}), 5, 1'b0, '0, 1'b0);

    // Coefficient write during RUN ignored; IDLE write and same-edge write honoured
    run_job("tc5_run_wr", XW'({$urandom(), $urandom()}), 0, 1'b0, '0, 1'b1);
    c_alt = CW'({$urandom(), $urandom()});
    load_coef(c_alt);
    run_job("tc5_idle_wr", XW'({$urandom(), $urandom()}), 1, 1'b0, '0, 1'b0);
    c_alt2 = CW'({$urandom(), $urandom()});
    run_job("tc5_same_edge", XW'({$urandom(), $urandom()}), 0, 1'b1, c_alt2, 1'b0);

    // Reset during RUN at bit 3
    in_valid = 1'b1;
    x_in = all_x(8'h5A);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("tc6_running", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("tc6_rst_in_ready", 64'(in_ready), 64'd1);
    chk("tc6_rst_busy", 64'(busy), 64'd0);
    chk("tc6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("tc6_rst_y", 64'(y), 64'd0);
    tick();
    rst_n = 1'b1;
    coef_shadow = '0;
    tick();
    run_job("tc6_cleared", all_x(8'h37), 0, 1'b0, '0, 1'b0);
    load_coef(c_tc1);
    run_job("tc6_reload", all_x(8'd49), 0, 1'b0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
